// File: rtl/window_line_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : window_line_ctrl
// Purpose  : Sequencer and line-buffer controller for a 3x3 window/kernel
//            stage. It takes a raster pixel stream, tracks the column and row
//            position, keeps the two previous lines in internal line RAMs and
//            presents three vertically aligned taps to the kernel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1      system clock
//   rst_n      in   1      synchronous reset, active-low
//   sof        in   1      start of frame, qualified by pix_valid, pixel (0,0)
//   pix_valid  in   1      input pixel valid (no backpressure)
//   pix_data   in   WIDTH  input pixel
//   win_valid  out  1      taps valid (kernel valid_in)
//   din1       out  WIDTH  pixel at (col, row-2)
//   din2       out  WIDTH  pixel at (col, row-1)
//   din3       out  WIDTH  pixel at (col, row)
//   win_border out  1      with win_valid: tap column < 2
//   frame_done out  1      pulse with the last win_valid of a frame
//   busy       out  1      frame in progress (FILL or RUN)
//   sof_err    out  1      pulse: sof arrived mid-frame, frame restarted
// ============================================================================
module window_line_ctrl #(
  parameter int WIDTH      = 24,
  parameter int PIC_WIDTH  = 320,
  parameter int PIC_HEIGHT = 240
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sof,
  input  logic             pix_valid,
  input  logic [WIDTH-1:0] pix_data,
  output logic             win_valid,
  output logic [WIDTH-1:0] din1,
  output logic [WIDTH-1:0] din2,
  output logic [WIDTH-1:0] din3,
  output logic             win_border,
  output logic             frame_done,
  output logic             busy,
  output logic             sof_err
);

  // Line RAM address width; the 9-bit counters are sliced down to this.
  localparam int          c_aw       = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
  localparam logic [8:0]  c_col_last = 9'(PIC_WIDTH - 1);
  localparam logic [8:0]  c_row_last = 9'(PIC_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [8:0]       r_col;
  logic [8:0]       r_row;

  logic [WIDTH-1:0] r_lb_a [0:PIC_WIDTH-1];   // row-1
  logic [WIDTH-1:0] r_lb_b [0:PIC_WIDTH-1];   // row-2

  logic             r_win_valid;
  logic [WIDTH-1:0] r_din1;
  logic [WIDTH-1:0] r_din2;
  logic [WIDTH-1:0] r_din3;
  logic             r_win_border;
  logic             r_frame_done;
  logic             r_sof_err;

  logic             w_accept;
  logic             w_restart;
  logic             w_tap;
  logic [8:0]       w_pcol;
  logic [8:0]       w_prow;
  logic             w_col_end;
  logic             w_row_end;
  logic             w_frame_last;
  logic             w_ram_wr;
  logic [c_aw-1:0]  w_addr;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  // --------------------------------------------------------------------------
  // Accept qualification and position of the pixel being accepted.
  // A qualified sof always names pixel (0,0), whatever the counters hold,
  // which is what makes a mid-frame sof a clean restart.
  // --------------------------------------------------------------------------
  assign w_accept     = pix_valid & ((r_state != S_IDLE) | sof);
  assign w_restart    = pix_valid & sof & (r_state != S_IDLE);
  assign w_pcol       = sof ? 9'd0 : r_col;
  assign w_prow       = sof ? 9'd0 : r_row;
  assign w_col_end    = (w_pcol == c_col_last);
  assign w_row_end    = (w_prow == c_row_last);

  // In RUN without sof the row is always >= 2, so a RUN accept is a tap.
  assign w_tap        = w_accept & ~sof & (r_state == S_RUN);
  assign w_frame_last = w_tap & w_col_end & w_row_end;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      if (sof) begin
        w_state_nxt = S_FILL;
      end else begin
        case (r_state)
          S_FILL: begin
            if (w_col_end && (w_prow == 9'd1)) begin
              w_state_nxt = S_RUN;
            end
          end
          S_RUN: begin
            if (w_col_end && w_row_end) begin
              w_state_nxt = S_IDLE;
            end
          end
          default: w_state_nxt = r_state;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Column / row counters. Row wraps to 0 on the last pixel of the frame so
  // the counters are already at (0,0) when the FSM returns to IDLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col <= 9'd0;
      r_row <= 9'd0;
    end else if (w_accept) begin
      if (w_col_end) begin
        r_col <= 9'd0;
        r_row <= w_row_end ? 9'd0 : (w_prow + 9'd1);
      end else begin
        r_col <= w_pcol + 9'd1;
        r_row <= w_prow;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Line RAMs. Read-before-write at the same column: the old lb_a entry
  // (previous line) shifts into lb_b while the new pixel lands in lb_a.
  // Contents are deliberately not reset; writes are blocked while in reset.
  // --------------------------------------------------------------------------
  assign w_ram_wr = w_accept & rst_n;
  assign w_addr   = w_pcol[c_aw-1:0];
  assign w_rd_a   = r_lb_a[w_addr];
  assign w_rd_b   = r_lb_b[w_addr];

  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      r_lb_a[w_addr] <= pix_data;
      r_lb_b[w_addr] <= w_rd_a;
    end
  end

  // --------------------------------------------------------------------------
  // Output stage: one clock from accept to taps. Taps only update on a
  // window-producing accept, so they hold while win_valid is low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win_valid  <= 1'b0;
      r_win_border <= 1'b0;
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
      r_din1       <= '0;
      r_din2       <= '0;
      r_din3       <= '0;
    end else begin
      r_win_valid  <= w_tap;
      r_win_border <= w_tap & (w_pcol < 9'd2);
      r_frame_done <= w_frame_last;
      r_sof_err    <= w_restart;
      if (w_tap) begin
        r_din1 <= w_rd_b;
        r_din2 <= w_rd_a;
        r_din3 <= pix_data;
      end
    end
  end

  assign win_valid  = r_win_valid;
  assign din1       = r_din1;
  assign din2       = r_din2;
  assign din3       = r_din3;
  assign win_border = r_win_border;
  assign frame_done = r_frame_done;
  assign sof_err    = r_sof_err;
  assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire
